// File: rtl/secam_line_sequencer.sv
// Per-line sequencer ahead of the SECAM chroma encoder: horizontal counter,
// Db/Dr line parity with frame resync, carrier gating and active-window U/V
// forwarding.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | after reset, waiting for the first newline
// BLANK  | carrier off (outside carrier window or no chroma on this line)
// PRE    | unmodulated carrier ahead of active video
// ACTIVE | carrier on, U/V passed through
// POST   | unmodulated carrier after active video
module secam_line_sequencer #(
    parameter int unsigned CARRIER_START   = 200,
    parameter int unsigned ACTIVE_START    = 260,
    parameter int unsigned ACTIVE_END      = 1500,
    parameter int unsigned CARRIER_END     = 1560,
    parameter bit          FIRST_LINE_EVEN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              newline,
    input  logic              newframe,
    input  logic              vblank,
    input  logic              color_enable,
    input  logic signed [7:0] in_u,
    input  logic signed [7:0] in_v,
    output logic              even_line,
    output logic              enabled,
    output logic signed [7:0] yuv_u,
    output logic signed [7:0] yuv_v
);

    typedef enum logic [2:0] {
        IDLE,
        BLANK,
        PRE,
        ACTIVE,
        POST
    } state_t;

    localparam logic [11:0] H_MAX   = 12'hFFF;
    localparam logic [11:0] C_START = 12'(CARRIER_START);
    localparam logic [11:0] A_START = 12'(ACTIVE_START);
    localparam logic [11:0] A_END   = 12'(ACTIVE_END);
    localparam logic [11:0] C_END   = 12'(CARRIER_END);

    // Window ordering must hold, and the carrier must close before the
    // saturation value so a stalled counter always decodes as BLANK.
    generate
        if (!(CARRIER_START > 0 && CARRIER_START <= ACTIVE_START &&
              ACTIVE_START <= ACTIVE_END && ACTIVE_END <= CARRIER_END &&
              CARRIER_END <= 4094)) begin : g_bad_params
            $error("secam_line_sequencer: invalid carrier/active window parameters");
        end
    endgenerate

    logic [11:0] h_cnt;
    logic        line_chroma;
    logic        resync_pending;
    state_t      state;
    state_t      state_next;

    // Horizontal position: restart on newline, otherwise count up and stick at max.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= H_MAX;
        end else if (newline) begin
            h_cnt <= '0;
        end else if (h_cnt != H_MAX) begin
            h_cnt <= h_cnt + 12'd1;
        end
    end

    // Per-line chroma qualifier, frozen for the whole line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_chroma <= 1'b0;
        end else if (newline) begin
            line_chroma <= color_enable & ~vblank;
        end
    end

    // Db/Dr parity: toggle each line, forced to the first-line value after a resync.
    // A newframe coinciding with newline resyncs that same line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resync_pending <= 1'b1;
            even_line      <= 1'b0;
        end else if (newline) begin
            resync_pending <= 1'b0;
            if (resync_pending || newframe) begin
                even_line <= FIRST_LINE_EVEN;
            end else begin
                even_line <= ~even_line;
            end
        end else if (newframe) begin
            resync_pending <= 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Decode the window from the current h_cnt; IDLE holds until the first newline.
    always_comb begin
        state_next = BLANK;
        if (state == IDLE && !newline) begin
            state_next = IDLE;
        end else if (!line_chroma || h_cnt < C_START || h_cnt >= C_END) begin
            state_next = BLANK;
        end else if (h_cnt < A_START) begin
            state_next = PRE;
        end else if (h_cnt < A_END) begin
            state_next = ACTIVE;
        end else begin
            state_next = POST;
        end
    end

    // Registered encoder controls, aligned with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enabled <= 1'b0;
            yuv_u   <= '0;
            yuv_v   <= '0;
        end else begin
            enabled <= (state_next == PRE) || (state_next == ACTIVE) || (state_next == POST);
            if (state_next == ACTIVE) begin
                yuv_u <= in_u;
                yuv_v <= in_v;
            end else begin
                yuv_u <= '0;
                yuv_v <= '0;
            end
        end
    end

endmodule

// File: tb/tb_secam_line_sequencer.sv
// Self-checking bench for secam_line_sequencer. Expected outputs come from a
// list of newline events (time, chroma flag, parity) and a history of U/V
// inputs; each cycle's outputs are derived from the latest relevant event.
module tb_secam_line_sequencer;

    localparam int CS   = 200;
    localparam int AS   = 260;
    localparam int AE   = 1500;
    localparam int CE   = 1560;
    localparam bit FLE  = 1'b1;
    localparam int LINE = 1716;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              newline = 1'b0;
    logic              newframe = 1'b0;
    logic              vblank = 1'b0;
    logic              color_enable = 1'b0;
    logic signed [7:0] in_u = '0;
    logic signed [7:0] in_v = '0;
    logic              even_line;
    logic              enabled;
    logic signed [7:0] yuv_u;
    logic signed [7:0] yuv_v;

    secam_line_sequencer #(
        .CARRIER_START  (CS),
        .ACTIVE_START   (AS),
        .ACTIVE_END     (AE),
        .CARRIER_END    (CE),
        .FIRST_LINE_EVEN(FLE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .newline     (newline),
        .newframe    (newframe),
        .vblank      (vblank),
        .color_enable(color_enable),
        .in_u        (in_u),
        .in_v        (in_v),
        .even_line   (even_line),
        .enabled     (enabled),
        .yuv_u       (yuv_u),
        .yuv_v       (yuv_v)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit rand_uv  = 1'b1;

    typedef struct {
        int t;
        bit chroma;
        bit par;
    } ev_t;

    ev_t               evq[$];
    bit                pending = 1'b1;
    logic signed [7:0] u_hist[int];
    logic signed [7:0] v_hist[int];

    // Record this cycle's inputs in the model, then advance one clock.
    task automatic tick();
        ev_t e;
        if (rand_uv) begin
            in_u = 8'($urandom);
            in_v = 8'($urandom);
        end
        u_hist[cyc] = in_u;
        v_hist[cyc] = in_v;
        if (newline && !rst) begin
            e.t      = cyc;
            e.chroma = color_enable && !vblank;
            if (pending || newframe) e.par = FLE;
            else if (evq.size() > 0) e.par = !evq[$].par;
            else e.par = 1'b1;
            pending = 1'b0;
            evq.push_back(e);
        end else if (newframe && !rst) begin
            pending = 1'b1;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic model_reset();
        evq.delete();
        pending = 1'b1;
    endtask

    // Expected {even_line, enabled, yuv_u, yuv_v} during cycle t.
    function automatic logic [17:0] expect_now(input int t);
        logic              ev, en;
        logic signed [7:0] u, v;
        int                k;
        ev = 1'b0; en = 1'b0; u = '0; v = '0; k = 0;
        for (int i = evq.size() - 1; i >= 0; i--) begin
            if (evq[i].t <= t - 1) begin
                ev = evq[i].par;
                break;
            end
        end
        for (int i = evq.size() - 1; i >= 0; i--) begin
            if (evq[i].t <= t - 2) begin
                k = t - evq[i].t - 2;
                if (evq[i].chroma && k >= CS && k < CE) en = 1'b1;
                if (evq[i].chroma && k >= AS && k < AE) begin
                    u = u_hist[t - 1];
                    v = v_hist[t - 1];
                end
                break;
            end
        end
        return {ev, en, u, v};
    endfunction

    task automatic test_reset();
        logic [17:0] e;
        rst = 1'b1;
        #1;
        checks++;
        if ({even_line, enabled, yuv_u, yuv_v} !== 18'h0) begin
            failures++;
            $display("FAIL reset_async got even=%b en=%b u=%0d v=%0d want all 0",
                     even_line, enabled, yuv_u, yuv_v);
        end
        model_reset();
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            e = expect_now(cyc);
            checks++;
            if ({even_line, enabled, yuv_u, yuv_v} !== e) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d got even=%b en=%b u=%0d v=%0d want even=%b en=%b u=%0d v=%0d",
                         cyc, even_line, enabled, yuv_u, yuv_v, e[17], e[16], $signed(e[15:8]), $signed(e[7:0]));
            end
            tick();
        end
    endtask

    task automatic test_normal_line();
        int          n, rel;
        logic        e_en;
        logic signed [7:0] e_u, e_v;
        rand_uv = 1'b0;
        in_u = 8'sd40;
        in_v = -8'sd30;
        color_enable = 1'b1;
        vblank = 1'b0;
        n = cyc;
        newline = 1'b1;
        tick();
        newline = 1'b0;
        for (int i = 0; i < LINE; i++) begin
            rel  = cyc - n;
            e_en = (rel >= CS + 2) && (rel < CE + 2);
            e_u  = (rel >= AS + 2 && rel <= AE + 1) ? 8'sd40 : 8'sd0;
            e_v  = (rel >= AS + 2 && rel <= AE + 1) ? -8'sd30 : 8'sd0;
            checks++;
            if ({even_line, enabled, yuv_u, yuv_v} !== {1'b1, e_en, e_u, e_v}) begin
                failures++;
                $display("FAIL normal_line rel=%0d got even=%b en=%b u=%0d v=%0d want even=1 en=%b u=%0d v=%0d",
                         rel, even_line, enabled, yuv_u, yuv_v, e_en, e_u, e_v);
            end
            tick();
        end
        rand_uv = 1'b1;
    endtask

    task automatic test_alternation();
        logic [17:0] e;
        bit          pat[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        rst = 1'b1;
        model_reset();
        tick();
        rst = 1'b0;
        tick();
        color_enable = 1'b1;
        vblank = 1'b0;
        for (int l = 0; l < 4; l++) begin
            newline = 1'b1;
            tick();
            newline = 1'b0;
            checks++;
            if (even_line !== pat[l]) begin
                failures++;
                $display("FAIL alternation line=%0d got even=%b want %b", l, even_line, pat[l]);
            end
            for (int i = 1; i < LINE; i++) begin
                e = expect_now(cyc);
                checks++;
                if ({even_line, enabled, yuv_u, yuv_v} !== e) begin
                    failures++;
                    $display("FAIL alternation cyc=%0d got even=%b en=%b u=%0d v=%0d want even=%b en=%b u=%0d v=%0d",
                             cyc, even_line, enabled, yuv_u, yuv_v, e[17], e[16], $signed(e[15:8]), $signed(e[7:0]));
                end
                tick();
            end
        end
    endtask

    // Enters with even_line = 0 after the alternation test.
    task automatic test_resync();
        logic [17:0] e;
        for (int l = 0; l < 3; l++) begin
            newline  = 1'b1;
            newframe = (l == 2);
            tick();
            newline  = 1'b0;
            newframe = 1'b0;
            if (l > 0) begin
                checks++;
                if (even_line !== 1'b1) begin
                    failures++;
                    $display("FAIL resync line=%0d coincident=%0d got even=%b want 1", l, l == 2, even_line);
                end
            end
            for (int i = 1; i < LINE; i++) begin
                newframe = (l == 0 && i == 700);
                e = expect_now(cyc);
                checks++;
                if ({even_line, enabled, yuv_u, yuv_v} !== e) begin
                    failures++;
                    $display("FAIL resync cyc=%0d got even=%b en=%b u=%0d v=%0d want even=%b en=%b u=%0d v=%0d",
                             cyc, even_line, enabled, yuv_u, yuv_v, e[17], e[16], $signed(e[15:8]), $signed(e[7:0]));
                end
                tick();
            end
            newframe = 1'b0;
        end
    endtask

    task automatic test_blanked();
        logic [17:0] e;
        bit          prev;
        prev = even_line;
        vblank = 1'b1;
        newline = 1'b1;
        tick();
        newline = 1'b0;
        vblank = 1'b0;
        checks++;
        if (even_line !== !prev) begin
            failures++;
            $display("FAIL blanked_toggle got even=%b want %b", even_line, !prev);
        end
        for (int i = 1; i < LINE; i++) begin
            e = expect_now(cyc);
            checks++;
            if ({even_line, enabled, yuv_u, yuv_v} !== {!prev, 1'b0, 16'h0} ||
                {even_line, enabled, yuv_u, yuv_v} !== e) begin
                failures++;
                $display("FAIL blanked cyc=%0d got even=%b en=%b u=%0d v=%0d want even=%b en=0 u=0 v=0",
                         cyc, even_line, enabled, yuv_u, yuv_v, !prev);
            end
            tick();
        end
    endtask

    task automatic test_midline_restart();
        logic [17:0] e;
        int          m, rel;
        color_enable = 1'b1;
        newline = 1'b1;
        tick();
        newline = 1'b0;
        repeat (800) tick();
        m = cyc;
        newline = 1'b1;
        tick();
        newline = 1'b0;
        for (int i = 0; i < LINE; i++) begin
            rel = cyc - m;
            e = expect_now(cyc);
            checks++;
            if ({even_line, enabled, yuv_u, yuv_v} !== e ||
                (rel == 1 && enabled !== 1'b1) || (rel == 2 && enabled !== 1'b0) ||
                (rel == CS + 2 && enabled !== 1'b1)) begin
                failures++;
                $display("FAIL midline rel=%0d got even=%b en=%b u=%0d v=%0d want even=%b en=%b u=%0d v=%0d",
                         rel, even_line, enabled, yuv_u, yuv_v, e[17], e[16], $signed(e[15:8]), $signed(e[7:0]));
            end
            tick();
        end
    endtask

    task automatic test_random_lines();
        logic [17:0] e;
        int          len;
        for (int l = 0; l < 10; l++) begin
            len = int'($urandom_range(2000, 150));
            color_enable = ($urandom_range(3, 0) != 0);
            vblank = ($urandom_range(4, 0) == 0);
            newline = 1'b1;
            newframe = ($urandom_range(3, 0) == 0);
            tick();
            newline = 1'b0;
            newframe = 1'b0;
            for (int i = 1; i < len; i++) begin
                newframe = ($urandom_range(799, 0) == 0);
                e = expect_now(cyc);
                checks++;
                if ({even_line, enabled, yuv_u, yuv_v} !== e) begin
                    failures++;
                    $display("FAIL random cyc=%0d got even=%b en=%b u=%0d v=%0d want even=%b en=%b u=%0d v=%0d",
                             cyc, even_line, enabled, yuv_u, yuv_v, e[17], e[16], $signed(e[15:8]), $signed(e[7:0]));
                end
                tick();
            end
            newframe = 1'b0;
        end
    endtask

    task automatic test_async_reset_stall();
        logic [17:0] e;
        color_enable = 1'b1;
        vblank = 1'b0;
        newline = 1'b1;
        tick();
        newline = 1'b0;
        repeat (400) tick();
        checks++;
        if (enabled !== 1'b1) begin
            failures++;
            $display("FAIL async_pre got en=%b want 1", enabled);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({enabled, yuv_u, yuv_v} !== 17'h0) begin
            failures++;
            $display("FAIL async_reset got en=%b u=%0d v=%0d want en=0 u=0 v=0", enabled, yuv_u, yuv_v);
        end
        model_reset();
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            e = expect_now(cyc);
            checks++;
            if ({even_line, enabled, yuv_u, yuv_v} !== e || enabled !== 1'b0) begin
                failures++;
                $display("FAIL stall cyc=%0d got even=%b en=%b u=%0d v=%0d want even=%b en=0 u=0 v=0",
                         cyc, even_line, enabled, yuv_u, yuv_v, e[17]);
            end
            tick();
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_normal_line();
        test_alternation();
        test_resync();
        test_blanked();
        test_midline_restart();
        test_random_lines();
        test_async_reset_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/secam_line_sequencer.md
# secam_line_sequencer

Per-line control stage directly upstream of the SECAM chroma encoder. It tracks horizontal position from a line-start pulse and sequences the SECAM Db/Dr line alternation. It generates the carrier gate, including the unmodulated pre- and post-carrier intervals around active video, and forwards U/V colour-difference samples only inside the active window. Its outputs drive the encoder's `even_line`, `enabled`, `yuv_u` and `yuv_v` inputs directly.

## Interface
- `CARRIER_START`, 200: h_cnt at which the carrier gate opens; unmodulated carrier begins.
- `ACTIVE_START`, 260: h_cnt at which U/V start passing through.
- `ACTIVE_END`, 1500: first h_cnt after the active window; U/V are forced to 0 from here.
- `CARRIER_END`, 1560: first h_cnt with the carrier gate closed.
- `FIRST_LINE_EVEN`, 1: value of `even_line` on the first line after reset or after a frame resync.
- Parameter constraint, checked by elaboration assertion: 0 < CARRIER_START ≤ ACTIVE_START ≤ ACTIVE_END ≤ CARRIER_END ≤ 4094.
- `clk`, in, 1: pixel clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `newline`, in, 1: single-cycle pulse marking the start of a line.
- `newframe`, in, 1: single-cycle pulse; arms a parity resync for the next line.
- `vblank`, in, 1: high when the coming line is vertically blanked; sampled on `newline`.
- `color_enable`, in, 1: global chroma enable; sampled on `newline`.
- `in_u`, in, 8 signed: U (Db) sample.
- `in_v`, in, 8 signed: V (Dr) sample.
- `even_line`, out, 1: 1 = Db line, 0 = Dr line.
- `enabled`, out, 1: carrier gate.
- `yuv_u`, out, 8 signed: gated U.
- `yuv_v`, out, 8 signed: gated V.

## Operation
- **h_cnt (12 bit)**
  - `newline` loads 0 into h_cnt for the next cycle.
  - Otherwise h_cnt increments and saturates at 4095; it never wraps.
- **Line flags**
  - On `newline`, `line_chroma <= color_enable & ~vblank`.
  - `line_chroma` stays constant for the rest of the line.
- **States**
  - IDLE: entered from reset; exited only on `newline`.
  - BLANK: h_cnt < CARRIER_START, or h_cnt ≥ CARRIER_END, or `line_chroma` = 0.
  - PRE: CARRIER_START ≤ h_cnt < ACTIVE_START.
  - ACTIVE: ACTIVE_START ≤ h_cnt < ACTIVE_END.
  - POST: ACTIVE_END ≤ h_cnt < CARRIER_END.
  - The state is decoded from h_cnt and `line_chroma` and registered.
  - Any `newline` forces the next h_cnt to 0, which aborts PRE/ACTIVE/POST mid-line.
- **Outputs, registered**
  - `enabled` = 1 in PRE, ACTIVE and POST.
  - `yuv_u` / `yuv_v` = the previous cycle's `in_u` / `in_v` in ACTIVE; 0 otherwise, so the encoder emits the rest-frequency carrier.
  - Both U and V are forwarded; the encoder selects between them using `even_line`.
- **Parity**
  - `newframe` sets `resync_pending`.
  - On `newline`:
    - If `resync_pending` is set, `even_line <= FIRST_LINE_EVEN` and `resync_pending` clears.
    - Otherwise `even_line` toggles.
  - `even_line` toggles on blanked lines as well.
  - `newframe` and `newline` in the same cycle: the resync applies to that line, and `resync_pending` ends cleared.
- **Reset values**
  - State: IDLE.
  - h_cnt = 4095, `line_chroma` = 0.
  - `resync_pending` = 1.
  - `even_line` = 0, `enabled` = 0, `yuv_u` = `yuv_v` = 0.

## Timing
- `newline` at cycle N:
  - h_cnt = 0 at N+1.
  - `even_line` updates at N+1.
- Outputs lag h_cnt by one cycle:
  - `enabled` rises at N+2+CARRIER_START and falls at N+2+CARRIER_END.
  - The first nonzero U/V output appears at N+2+ACTIVE_START and carries `in_u`/`in_v` sampled at N+1+ACTIVE_START.
  - The last active U/V output appears at N+1+ACTIVE_END.
- `newline` while ACTIVE at cycle M: `enabled` = 0 and U/V = 0 from M+2.
- No `newline` for more than 4095 cycles: h_cnt saturates and the state stays BLANK.
- Reset asserted mid-line:
  - All outputs go to their reset values asynchronously.
  - Outputs stay at reset values until the first `newline` after release.

## Test plan
- **Reset, then normal line.** Reset, then `newline` at cycle 10 with `color_enable`=1, `vblank`=0, `in_u`=+40, `in_v`=-30.
  - Required: `even_line`=1 from cycle 11.
  - Required: `enabled` rises at cycle 212 and falls at 1572.
  - Required: `yuv_u`=+40 and `yuv_v`=-30 over cycles 272..1511; 0 elsewhere.
- **Line alternation.** Four `newline` pulses 1716 cycles apart.
  - Required: `even_line` = 1, 0, 1, 0.
- **Frame resync.** `newframe` pulses while `even_line`=1; next `newline` follows.
  - Required: `even_line` stays 1 and does not toggle.
  - Repeat with `newframe` and `newline` coincident: same result.
- **Blanked line.** `newline` with `vblank`=1.
  - Required: `enabled`=0 and U/V = 0 for the whole line; `even_line` still toggles.
- **Mid-line restart.** `newline` at h_cnt=800, inside ACTIVE.
  - Required: `enabled`=0 two cycles later.
  - Required: `enabled` re-rises CARRIER_START+2 cycles after the pulse.
- **Asynchronous reset and missing newline.**
  - `rst` pulsed mid-ACTIVE: `enabled`, `yuv_u` and `yuv_v` go to 0 immediately, with no clock edge needed.
  - Then 5000 cycles with no `newline`: `enabled` stays 0.
